// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory arbiter: FSM states, requester ids
// and the default legal address ceiling.
package data_mem_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0000_FFFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the port not served last wins.
// The last-served pointer only moves when a grant is actually taken.
module rr_arb2
  import data_mem_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == PORT_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset value "B served last" makes A the first winner under contention.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last <= PORT_B;
    end else if (advance && (gnt != 2'b00)) begin
      last <= gnt[1] ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and access sequencer between the MEM stage (port A),
// the debug/DMA port (port B) and the data memory. Each access is IDLE->ACCESS->DONE.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(DEFAULT_ADDR_LIMIT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_a,
  input  logic             i_we_a,
  input  logic [WIDTH-1:0] i_addr_a,
  input  logic [WIDTH-1:0] i_wdata_a,
  output logic             o_ack_a,
  output logic             o_err_a,
  output logic [WIDTH-1:0] o_rdata_a,
  input  logic             i_req_b,
  input  logic             i_we_b,
  input  logic [WIDTH-1:0] i_addr_b,
  input  logic [WIDTH-1:0] i_wdata_b,
  output logic             o_ack_b,
  output logic             o_err_b,
  output logic [WIDTH-1:0] o_rdata_b,
  output logic [WIDTH-1:0] o_mem_address,
  output logic [WIDTH-1:0] o_mem_data,
  output logic             o_mem_we,
  output logic             o_mem_re,
  input  logic [WIDTH-1:0] i_mem_data
);

  logic [1:0]       state;
  logic [1:0]       gnt;
  logic             lat_port;
  logic             lat_err;
  logic             sel_port;
  logic             sel_we;
  logic             sel_in_range;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .req     ({i_req_b, i_req_a}),
    .advance (state == ST_IDLE),
    .gnt     (gnt)
  );

  always_comb begin
    sel_port     = gnt[1] ? PORT_B : PORT_A;
    sel_we       = gnt[1] ? i_we_b    : i_we_a;
    sel_addr     = gnt[1] ? i_addr_b  : i_addr_a;
    sel_wdata    = gnt[1] ? i_wdata_b : i_wdata_a;
    sel_in_range = (sel_addr <= ADDR_LIMIT);
  end

  // The memory drive registers double as the latched operation; they are
  // non-zero only during ACCESS, and an out-of-range op keeps both strobes low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      lat_port      <= PORT_A;
      lat_err       <= 1'b0;
      o_mem_address <= '0;
      o_mem_data    <= '0;
      o_mem_we      <= 1'b0;
      o_mem_re      <= 1'b0;
      o_ack_a       <= 1'b0;
      o_ack_b       <= 1'b0;
      o_err_a       <= 1'b0;
      o_err_b       <= 1'b0;
      o_rdata_a     <= '0;
      o_rdata_b     <= '0;
    end else begin
      o_ack_a <= 1'b0;
      o_ack_b <= 1'b0;
      o_err_a <= 1'b0;
      o_err_b <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            lat_port      <= sel_port;
            lat_err       <= ~sel_in_range;
            o_mem_address <= sel_addr;
            o_mem_data    <= sel_wdata;
            o_mem_we      <= sel_we & sel_in_range;
            o_mem_re      <= ~sel_we & sel_in_range;
            state         <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          o_mem_address <= '0;
          o_mem_data    <= '0;
          o_mem_we      <= 1'b0;
          o_mem_re      <= 1'b0;
          if (lat_port == PORT_A) begin
            o_ack_a <= 1'b1;
            o_err_a <= lat_err;
            if (o_mem_re) o_rdata_a <= i_mem_data;
          end else begin
            o_ack_b <= 1'b1;
            o_err_b <= lat_err;
            if (o_mem_re) o_rdata_b <= i_mem_data;
          end
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data memory model.
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_a, i_we_a, i_req_b, i_we_b;
  logic [31:0] i_addr_a, i_wdata_a, i_addr_b, i_wdata_b;
  logic        o_ack_a, o_err_a, o_ack_b, o_err_b;
  logic [31:0] o_rdata_a, o_rdata_b;
  logic [31:0] o_mem_address, o_mem_data, i_mem_data;
  logic        o_mem_we, o_mem_re;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  data_mem_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_a(i_req_a), .i_we_a(i_we_a), .i_addr_a(i_addr_a), .i_wdata_a(i_wdata_a),
    .o_ack_a(o_ack_a), .o_err_a(o_err_a), .o_rdata_a(o_rdata_a),
    .i_req_b(i_req_b), .i_we_b(i_we_b), .i_addr_b(i_addr_b), .i_wdata_b(i_wdata_b),
    .o_ack_b(o_ack_b), .o_err_b(o_err_b), .o_rdata_b(o_rdata_b),
    .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
    .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .i_mem_data(i_mem_data)
  );

  // Memory model: unwritten words read back as 32'h1000_0000 + index.
  logic [31:0]  mem [0:255];
  logic [255:0] written = '0;

  always @(posedge i_clk) begin
    if (o_mem_we) begin
      mem[o_mem_address[7:0]]     <= o_mem_data;
      written[o_mem_address[7:0]] <= 1'b1;
    end
  end

  assign i_mem_data = written[o_mem_address[7:0]] ? mem[o_mem_address[7:0]]
                                                  : 32'h1000_0000 + {24'd0, o_mem_address[7:0]};

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Runs one single-port transaction starting at a falling edge.
  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, output int ack_cyc, output int strobe_cyc,
                               output int we_cnt, output int re_cnt, output int other_ack,
                               output logic [31:0] rdata, output logic err);
    ack_cyc = 0; strobe_cyc = 0; we_cnt = 0; re_cnt = 0; other_ack = 0;
    rdata = '0; err = 1'b0;
    if (port == PORT_A) begin
      i_req_a = 1'b1; i_we_a = we; i_addr_a = addr; i_wdata_a = wdata;
    end else begin
      i_req_b = 1'b1; i_we_b = we; i_addr_b = addr; i_wdata_b = wdata;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (o_mem_we) we_cnt++;
      if (o_mem_re) re_cnt++;
      if ((o_mem_we || o_mem_re) && strobe_cyc == 0) strobe_cyc = c;
      if (port == PORT_A ? o_ack_b : o_ack_a) other_ack++;
      if (port == PORT_A ? o_ack_a : o_ack_b) begin
        ack_cyc = c;
        rdata   = (port == PORT_A) ? o_rdata_a : o_rdata_b;
        err     = (port == PORT_A) ? o_err_a : o_err_b;
        break;
      end
    end
    i_req_a = 1'b0;
    i_req_b = 1'b0;
    @(negedge i_clk);
  endtask

  int          ack_cyc, strobe_cyc, we_cnt, re_cnt, other_ack, cnt_a, cnt_we;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  exp_acks;
  string       nm;

  initial begin
    vecs[0] = '{PORT_A, 1'b1, 32'd5,          32'hDEAD_BEEF, 32'h1000_0003, 1'b0};
    vecs[1] = '{PORT_A, 1'b0, 32'd5,          32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{PORT_B, 1'b1, 32'd9,          32'hFFFF_FFF6, 32'h1000_0004, 1'b0};
    vecs[3] = '{PORT_B, 1'b0, 32'd9,          32'h0,         32'hFFFF_FFF6, 1'b0};
    vecs[4] = '{PORT_B, 1'b0, 32'h0001_0000,  32'h0,         32'hFFFF_FFF6, 1'b1};
    vecs[5] = '{PORT_A, 1'b0, 32'd3,          32'h0,         32'h1000_0003, 1'b0};
    vecs[6] = '{PORT_A, 1'b1, 32'h0000_FFFF,  32'h1234_5678, 32'h1000_0003, 1'b0};
    vecs[7] = '{PORT_A, 1'b0, 32'h0000_FFFF,  32'h0,         32'h1234_5678, 1'b0};
    vecs[8] = '{PORT_A, 1'b1, 32'h0001_0000,  32'h0000_0BAD, 32'h1234_5678, 1'b1};
    vecs[9] = '{PORT_A, 1'b0, 32'd0,          32'h0,         32'h1000_0000, 1'b0};

    i_rst = 1'b1;
    i_req_a = 1'b0; i_we_a = 1'b0; i_addr_a = '0; i_wdata_a = '0;
    i_req_b = 1'b0; i_we_b = 1'b0; i_addr_b = '0; i_wdata_b = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("reset_flags", {26'd0, o_ack_a, o_ack_b, o_err_a, o_err_b, o_mem_we, o_mem_re}, 32'd0);
    checkOutput("reset_rdata_a", o_rdata_a, 32'd0);
    checkOutput("reset_rdata_b", o_rdata_b, 32'd0);
    checkOutput("reset_mem_addr", o_mem_address, 32'd0);

    // Held contention from reset: A first, then alternate, one access every 3 cycles.
    i_req_a = 1'b1; i_we_a = 1'b0; i_addr_a = 32'd3;
    i_req_b = 1'b1; i_we_b = 1'b0; i_addr_b = 32'd4;
    for (int c = 1; c <= 11; c++) begin
      @(negedge i_clk);
      exp_acks = (c == 2 || c == 8) ? 2'b10 : (c == 5 || c == 11) ? 2'b01 : 2'b00;
      nm = $sformatf("rr_acks_cyc%0d", c);
      checkOutput(nm, {30'd0, o_ack_a, o_ack_b}, {30'd0, exp_acks});
    end
    i_req_a = 1'b0; i_req_b = 1'b0;
    @(negedge i_clk);
    checkOutput("rr_rdata_a", o_rdata_a, 32'h1000_0003);
    checkOutput("rr_rdata_b", o_rdata_b, 32'h1000_0004);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    ack_cyc, strobe_cyc, we_cnt, re_cnt, other_ack, rdata, err);
      checkOutput($sformatf("vec%0d_ack_cycle", i), ack_cyc, 2);
      checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d_we_pulses", i), we_cnt,
                  (vecs[i].we && !vecs[i].exp_err) ? 1 : 0);
      checkOutput($sformatf("vec%0d_re_pulses", i), re_cnt,
                  (!vecs[i].we && !vecs[i].exp_err) ? 1 : 0);
      checkOutput($sformatf("vec%0d_strobe_cycle", i), strobe_cyc, vecs[i].exp_err ? 0 : 1);
      checkOutput($sformatf("vec%0d_other_ack", i), other_ack, 0);
    end

    // Reset during the ACCESS cycle of a write must suppress the write.
    i_req_a = 1'b1; i_we_a = 1'b1; i_addr_a = 32'd7; i_wdata_a = 32'h0000_CAFE;
    @(negedge i_clk);
    checkOutput("rst_mid_we_before", {31'd0, o_mem_we}, 32'd1);
    i_rst = 1'b1;
    #1;
    checkOutput("rst_mid_we_after", {31'd0, o_mem_we}, 32'd0);
    checkOutput("rst_mid_mem_addr", o_mem_address, 32'd0);
    i_req_a = 1'b0; i_we_a = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("rst_mid_flags", {26'd0, o_ack_a, o_ack_b, o_err_a, o_err_b, o_mem_we, o_mem_re}, 32'd0);
    checkOutput("rst_mid_rdata_a", o_rdata_a, 32'd0);
    checkOutput("rst_mid_rdata_b", o_rdata_b, 32'd0);
    applyStimulus(PORT_A, 1'b0, 32'd7, 32'd0, ack_cyc, strobe_cyc, we_cnt, re_cnt, other_ack, rdata, err);
    checkOutput("rst_mid_readback", rdata, 32'h1000_0007);
    checkOutput("rst_mid_readback_ack", ack_cyc, 2);

    // A pulses its request only while B owns the access: it must be dropped.
    i_req_b = 1'b1; i_we_b = 1'b0; i_addr_b = 32'd20;
    @(negedge i_clk);
    i_req_a = 1'b1; i_we_a = 1'b1; i_addr_a = 32'd2; i_wdata_a = 32'h55;
    @(negedge i_clk);
    i_req_a = 1'b0; i_we_a = 1'b0;
    checkOutput("pulse_b_ack", {31'd0, o_ack_b}, 32'd1);
    checkOutput("pulse_b_rdata", o_rdata_b, 32'h1000_0014);
    i_req_b = 1'b0;
    cnt_a = 0; cnt_we = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_ack_a) cnt_a++;
      if (o_mem_we) cnt_we++;
    end
    checkOutput("pulse_a_never_acked", cnt_a, 0);
    checkOutput("pulse_a_no_write", cnt_we, 0);
    applyStimulus(PORT_B, 1'b1, 32'd20, 32'h77, ack_cyc, strobe_cyc, we_cnt, re_cnt, other_ack, rdata, err);
    checkOutput("pulse_next_b_ack", ack_cyc, 2);
    checkOutput("pulse_next_b_we", we_cnt, 1);
    checkOutput("pulse_next_other_ack", other_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
